fast2slow_buffer: RTL and testbench
===================================

FAST2SLOW_BUFFER -- requirements
Module: fast2slow_buffer

Interface
REQ-001: Parameter DWIDTH, default 128, data width in bits; SHALL be a multiple of 8.
REQ-002: Parameter RATIO, default 2, fast-to-slow clock ratio; SHALL be >= 2.
REQ-003: Parameter DEPTH, default 4, buffer entries; SHALL be a power of two, >= 2.
REQ-004: clk  in  1  fast clock; the only clock.
REQ-005: rst  in  1  synchronous, active-high reset.
REQ-006: clk_cnt  in  $clog2(RATIO)  fast-cycle phase within the slow period; 0 marks the slow clock edge.
REQ-007: s_axis_tdata / s_axis_tkeep / s_axis_tlast / s_axis_tvalid  in  DWIDTH / DWIDTH/8 / 1 / 1  fast-side AXI-Stream input.
REQ-008: s_axis_tready  out  1  fast-side ready.
REQ-009: m_axis_tdata / m_axis_tkeep / m_axis_tlast / m_axis_tvalid  out  DWIDTH / DWIDTH/8 / 1 / 1  slow-timed AXI-Stream output.
REQ-010: m_axis_tready  in  1  slow-domain ready, driven by a slow-clock register.

Function
REQ-011: Launch edge is the fast edge where clk_cnt == 0; the block SHALL sample m_axis_tready and change any m_axis_* output only on launch edges.
REQ-012: The block SHALL hold a circular FIFO of DEPTH entries {tdata, tkeep, tlast}, with read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, and an occupancy count of 0..DEPTH.
REQ-013: A beat SHALL be written on any fast edge where s_axis_tvalid & s_axis_tready, regardless of clk_cnt.
REQ-014: s_axis_tready SHALL be a register equal to (next count != DEPTH), with no combinational path from any input.
REQ-015: On a launch edge with (~m_axis_tvalid | m_axis_tready): if the pre-edge count > 0, pop the head into m_axis_tdata/tkeep/tlast and set m_axis_tvalid = 1; otherwise set m_axis_tvalid = 0.
REQ-016: On a launch edge with m_axis_tvalid & ~m_axis_tready, all m_axis_* outputs SHALL hold.
REQ-017: A beat written on a launch edge SHALL NOT be popped on that same edge; there is no write-to-output bypass.
REQ-018: A simultaneous write and pop SHALL leave the count unchanged; pointers advance independently.
REQ-019: Latency from acceptance to m_axis_tvalid = 1 SHALL be 1 to RATIO fast cycles when the FIFO is empty and the output is free.
REQ-020: Sustained output rate SHALL be one beat per RATIO fast cycles; each beat SHALL stay on m_axis_* for a whole number of slow periods.
REQ-021: Beat order and tkeep/tlast SHALL be preserved exactly; no beat is dropped or duplicated.
REQ-022: Total capacity SHALL be DEPTH + 1 beats (FIFO plus output register).

Reset
REQ-023: While rst is high, the block SHALL set count = 0, both pointers = 0, s_axis_tready = 1, m_axis_tvalid = 0, and m_axis_tdata/tkeep/tlast = 0.
REQ-024: A reset mid-operation SHALL discard all buffered and presented beats; none SHALL appear after reset.
REQ-025: Reset SHALL take priority over any simultaneous write or launch event.

Verification (RATIO=2, DEPTH=4, DWIDTH=128)
REQ-026: Drive one beat tdata=0xA5, tkeep=all-ones, tlast=1 accepted at clk_cnt=1, with m_axis_tready=1 -> m_axis_tvalid=1 with 0xA5/tlast=1 on the next edge; it is held exactly 2 cycles, then tvalid=0.
REQ-027: Offer beats 0..5 continuously with m_axis_tready=0 -> exactly 5 accepted, then s_axis_tready=0; m_axis_tdata=beat0 stays stable.
REQ-028: In the REQ-027 state, raise m_axis_tready=1 -> beats 0..5 emerge in order, one per 2 cycles, each held 2 cycles; s_axis_tready returns to 1 the cycle after the first pop.
REQ-029: Drive m_axis_tready=1 only on clk_cnt=1 cycles while tvalid=1 -> no transfer; outputs unchanged.
REQ-030: With count=3, write and pop on the same launch edge -> count stays 3, s_axis_tready stays 1, and order is preserved across pointer wrap.
REQ-031: Assert rst for 1 cycle with 3 beats buffered -> next cycle m_axis_tvalid=0 and s_axis_tready=1; only post-reset beats appear afterwards.

Source files
------------

// File: rtl/fast2slow_buffer.sv
// ---------------------------------------------------------------------------
// fast2slow_buffer
//
// Carries an AXI-Stream from a fast clock into a slow-timed consumer while
// everything runs on the single fast clock. The slow clock is represented by
// clk_cnt, the fast-cycle phase within one slow period; phase 0 is the slow
// clock edge ("launch edge"). Beats are accepted on any fast edge into a small
// circular FIFO. They are presented on the m_axis_* side only on launch edges,
// so every output beat is held for a whole number of slow periods.
//
// Parameters
//   DWIDTH : data width in bits, multiple of 8
//   RATIO  : fast-to-slow clock ratio, >= 2
//   DEPTH  : FIFO entries, power of two, >= 2
//
// Ports
//   clk            fast clock, the only clock
//   rst            synchronous active-high reset
//   clk_cnt        fast-cycle phase in the slow period, 0 = slow edge
//   s_axis_*       fast-side AXI-Stream input (tready is registered)
//   m_axis_*       slow-timed AXI-Stream output (all registered)
//   m_axis_tready  slow-domain ready, driven from a slow-clock register
// ---------------------------------------------------------------------------
module fast2slow_buffer #(
  parameter int DWIDTH = 128,
  parameter int RATIO  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(RATIO)-1:0] clk_cnt,
  input  logic [DWIDTH-1:0]        s_axis_tdata,
  input  logic [DWIDTH/8-1:0]      s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic [DWIDTH/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int KW   = DWIDTH / 8;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  // FIFO storage; contents need no reset because the pointers and count
  // define which entries are meaningful.
  logic [DWIDTH-1:0] dataMem [DEPTH];
  logic [KW-1:0]     keepMem [DEPTH];
  logic              lastMem [DEPTH];

  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              sReady_q, sReady_d;
  logic [DWIDTH-1:0] mData_q, mData_d;
  logic [KW-1:0]     mKeep_q, mKeep_d;
  logic              mLast_q, mLast_d;
  logic              mValid_q, mValid_d;

  logic launch;
  logic wrEn;
  logic outFree;
  logic popEn;

  // Handshake decode. The pop decision uses the pre-edge count, so a beat
  // written on a launch edge can never be popped on that same edge.
  always_comb begin
    launch  = (clk_cnt == '0);
    wrEn    = s_axis_tvalid & sReady_q;
    outFree = ~mValid_q | m_axis_tready;
    popEn   = launch & outFree & (count_q != '0);
  end

  // Next-state for pointers, occupancy and the registered ready. Ready is
  // derived from the next count so that the FIFO never overflows while
  // still having no combinational path from any input to s_axis_tready.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    unique case ({wrEn, popEn})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    sReady_d = (count_d != CNT_FULL);
  end

  // Output register next-state. Outside launch edges, or while a beat is
  // stalled by the consumer, everything holds. When the output is free on
  // a launch edge it either loads the FIFO head or goes idle.
  always_comb begin
    mData_d  = mData_q;
    mKeep_d  = mKeep_q;
    mLast_d  = mLast_q;
    mValid_d = mValid_q;
    if (launch && outFree) begin
      mValid_d = (count_q != '0);
      if (popEn) begin
        mData_d = dataMem[rdPtr_q];
        mKeep_d = keepMem[rdPtr_q];
        mLast_d = lastMem[rdPtr_q];
      end
    end
  end

  // FIFO write port. Writes are suppressed during reset so nothing from a
  // reset cycle can leak into the storage.
  always_ff @(posedge clk) begin
    if (!rst && wrEn) begin
      dataMem[wrPtr_q] <= s_axis_tdata;
      keepMem[wrPtr_q] <= s_axis_tkeep;
      lastMem[wrPtr_q] <= s_axis_tlast;
    end
  end

  // State registers. Reset wins over any simultaneous write or launch and
  // discards everything buffered or presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      sReady_q <= 1'b1;
      mData_q  <= '0;
      mKeep_q  <= '0;
      mLast_q  <= 1'b0;
      mValid_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      sReady_q <= sReady_d;
      mData_q  <= mData_d;
      mKeep_q  <= mKeep_d;
      mLast_q  <= mLast_d;
      mValid_q <= mValid_d;
    end
  end

  assign s_axis_tready = sReady_q;
  assign m_axis_tdata  = mData_q;
  assign m_axis_tkeep  = mKeep_q;
  assign m_axis_tlast  = mLast_q;
  assign m_axis_tvalid = mValid_q;

endmodule

// File: tb/tb_fast2slow_buffer.sv
// ---------------------------------------------------------------------------
// tb_fast2slow_buffer
//
// Self-checking bench for fast2slow_buffer (RATIO=2, DEPTH=4, DWIDTH=128).
// A queue-based reference model tracks the FIFO contents, the presented beat
// and the expected ready. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_fast2slow_buffer;

  localparam int DWIDTH = 128;
  localparam int RATIO  = 2;
  localparam int DEPTH  = 4;
  localparam int KW     = DWIDTH / 8;
  localparam int CW     = $clog2(RATIO);
  localparam int NBEATS = 64;
  localparam int A5IDX  = 63;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     clkCnt;
  logic [DWIDTH-1:0] sData;
  logic [KW-1:0]     sKeep;
  logic              sLast;
  logic              sValid;
  logic              sReady;
  logic [DWIDTH-1:0] mData;
  logic [KW-1:0]     mKeep;
  logic              mLast;
  logic              mValid;
  logic              mReady;

  // Fast clock
  always #5 clk = ~clk;

  fast2slow_buffer #(
    .DWIDTH(DWIDTH),
    .RATIO (RATIO),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_cnt      (clkCnt),
    .s_axis_tdata (sData),
    .s_axis_tkeep (sKeep),
    .s_axis_tlast (sLast),
    .s_axis_tvalid(sValid),
    .s_axis_tready(sReady),
    .m_axis_tdata (mData),
    .m_axis_tkeep (mKeep),
    .m_axis_tlast (mLast),
    .m_axis_tvalid(mValid),
    .m_axis_tready(mReady)
  );

  beat_t             beats [NBEATS];
  beat_t             modelQ[$];
  beat_t             modelOut;
  logic              modelValid;
  logic              modelReady;
  logic [DWIDTH-1:0] emitted[$];
  int                compared;
  int                mismatched;
  int                phase;
  int                nextBeat;
  int                acceptedCount;
  int                startIdx;
  logic              dutAcc;
  logic              mrVar;
  string             curTag;

  function automatic beat_t randomBeat();
    beat_t b;
    for (int w = 0; w < DWIDTH / 32; w++) begin
      b.data[w*32 +: 32] = $urandom;
    end
    b.keep = KW'($urandom);
    b.last = 1'($urandom);
    return b;
  endfunction

  task automatic checkValue(input string tag, input logic [DWIDTH-1:0] observed,
                            input logic [DWIDTH-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: advance one fast edge using the pre-edge inputs.
  task automatic modelStep();
    logic acc;
    acc = sValid & modelReady;
    if (rst) begin
      modelQ.delete();
      modelOut   = '0;
      modelValid = 1'b0;
      modelReady = 1'b1;
    end else begin
      if (clkCnt == '0 && (!modelValid || mReady)) begin
        if (modelQ.size() > 0) begin
          modelOut   = modelQ.pop_front();
          modelValid = 1'b1;
        end else begin
          modelValid = 1'b0;
        end
      end
      if (acc) begin
        modelQ.push_back('{data: sData, keep: sKeep, last: sLast});
      end
      modelReady = (modelQ.size() != DEPTH);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_tready"}, DWIDTH'(sReady), DWIDTH'(modelReady));
    checkValue({tag, "_tvalid"}, DWIDTH'(mValid), DWIDTH'(modelValid));
    checkValue({tag, "_tdata"},  mData,           modelOut.data);
    checkValue({tag, "_tkeep"},  DWIDTH'(mKeep),  DWIDTH'(modelOut.keep));
    checkValue({tag, "_tlast"},  DWIDTH'(mLast),  DWIDTH'(modelOut.last));
  endtask

  // One fast cycle: drive inputs, clock, advance model, compare #1 later.
  task automatic applyStimulus(input logic v, input int idx, input logic mr, input logic r);
    rst    = r;
    sValid = v;
    sData  = beats[idx].data;
    sKeep  = beats[idx].keep;
    sLast  = beats[idx].last;
    mReady = mr;
    clkCnt = CW'(phase);
    dutAcc = v & sReady & ~r;
    if (!r && clkCnt == '0 && mValid && mr) begin
      emitted.push_back(mData);
    end
    @(posedge clk);
    modelStep();
    #1;
    phase = (phase + 1) % RATIO;
    checkOutput(curTag);
  endtask

  task automatic offer(input logic mr);
    applyStimulus(1'b1, nextBeat % A5IDX, mr, 1'b0);
    if (dutAcc) begin
      nextBeat++;
      acceptedCount++;
    end
  endtask

  task automatic checkEmitted(input string tag, input int first, input int n);
    checkValue({tag, "_count"}, DWIDTH'(emitted.size()), DWIDTH'(n));
    for (int i = 0; i < n; i++) begin
      checkValue({tag, "_order"}, (i < emitted.size()) ? emitted[i] : 'x,
                 beats[(first + i) % A5IDX].data);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    phase      = 0;
    nextBeat   = 0;
    modelQ.delete();
    modelOut   = '0;
    modelValid = 1'b0;
    modelReady = 1'b1;
    for (int i = 0; i < NBEATS; i++) begin
      beats[i] = randomBeat();
    end
    beats[A5IDX].data = DWIDTH'(8'hA5);
    beats[A5IDX].keep = '1;
    beats[A5IDX].last = 1'b1;
    rst    = 1'b1;
    sValid = 1'b0;
    mReady = 1'b0;
    clkCnt = '0;
    sData  = '0;
    sKeep  = '0;
    sLast  = 1'b0;

    // Reset state
    curTag = "reset";
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkValue("reset_tready_const", DWIDTH'(sReady), DWIDTH'(1));
    checkValue("reset_tvalid_const", DWIDTH'(mValid), DWIDTH'(0));
    checkValue("reset_tdata_const",  mData, '0);

    // Single beat accepted at clk_cnt=1 with the consumer ready
    curTag = "single";
    while (phase != 1) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, A5IDX, 1'b1, 1'b0);
    checkValue("single_accept", DWIDTH'(dutAcc), DWIDTH'(1));
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkValue("single_valid_c1", DWIDTH'(mValid), DWIDTH'(1));
    checkValue("single_data_c1",  mData, DWIDTH'(8'hA5));
    checkValue("single_last_c1",  DWIDTH'(mLast), DWIDTH'(1));
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkValue("single_valid_c2", DWIDTH'(mValid), DWIDTH'(1));
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkValue("single_valid_c3", DWIDTH'(mValid), DWIDTH'(0));

    // Fill with the consumer stalled: capacity is DEPTH + 1
    curTag        = "fill";
    nextBeat      = 0;
    acceptedCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (nextBeat <= 5) offer(1'b0);
      else applyStimulus(1'b0, 0, 1'b0, 1'b0);
    end
    checkValue("fill_accepted", DWIDTH'(acceptedCount), DWIDTH'(DEPTH + 1));
    checkValue("fill_tready",   DWIDTH'(sReady), DWIDTH'(0));
    checkValue("fill_head",     mData, beats[0].data);

    // Release the consumer: beats 0..5 drain in order
    curTag = "drain";
    emitted.delete();
    for (int i = 0; i < 20; i++) begin
      if (nextBeat <= 5) offer(1'b1);
      else applyStimulus(1'b0, 0, 1'b1, 1'b0);
    end
    checkEmitted("drain", 0, 6);

    // Ready raised only off the launch edge: no transfer may happen
    curTag        = "noXfer";
    nextBeat      = 10;
    acceptedCount = 0;
    for (int i = 0; i < 4 && acceptedCount == 0; i++) offer(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, (phase == 1), 1'b0);
    checkValue("noXfer_valid", DWIDTH'(mValid), DWIDTH'(1));
    checkValue("noXfer_data",  mData, beats[10].data);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Simultaneous write and pop with three beats buffered
    curTag        = "wrPop";
    emitted.delete();
    nextBeat      = 20;
    startIdx      = 20;
    acceptedCount = 0;
    for (int i = 0; i < 12 && acceptedCount < 4; i++) offer(1'b0);
    while (phase != 0) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    offer(1'b1);
    checkValue("wrPop_accept", DWIDTH'(dutAcc), DWIDTH'(1));
    checkValue("wrPop_tready", DWIDTH'(sReady), DWIDTH'(1));
    offer(1'b1);
    offer(1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkEmitted("wrPop", startIdx, acceptedCount);

    // Reset with beats buffered discards them all
    curTag        = "resetMid";
    nextBeat      = 30;
    acceptedCount = 0;
    for (int i = 0; i < 12 && acceptedCount < 4; i++) offer(1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkValue("resetMid_tvalid", DWIDTH'(mValid), DWIDTH'(0));
    checkValue("resetMid_tready", DWIDTH'(sReady), DWIDTH'(1));
    emitted.delete();
    nextBeat      = 40;
    acceptedCount = 0;
    for (int i = 0; i < 12 && acceptedCount < 3; i++) offer(1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkEmitted("resetMid", 40, 3);

    // Randomized traffic; the consumer's ready changes only after launch edges
    curTag = "random";
    mrVar  = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (phase == 1) mrVar = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1'b0, 0, mrVar, 1'b1);
      end else if ($urandom_range(0, 2) != 0) begin
        offer(mrVar);
      end else begin
        applyStimulus(1'b0, 0, mrVar, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
